dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 41 ++++
 rtl/dmem_ctrl.sv | 113 +++++++++++
 tb/tb_dmem_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and access descriptor for the data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access attributes kept from acceptance until the response is produced.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] offset;
    logic       err;
  } acc_t;

  // Illegal size encodings count as misaligned so a single check covers both.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: size_misaligned = 1'b0;
      SZ_HALF: size_misaligned = offset[0];
      SZ_WORD: size_misaligned = (offset != 2'b00);
      default: size_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between a load/store client and dmem_ctrl.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replication and load lane select with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [31:0] shifted;

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata;
    rdata_c = 32'd0;
    shifted = rword >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << offset;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_c    = 4'b0011 << offset;
        wdata_c = {2{wdata[15:0]}};
        rdata_c = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_c    = 4'b1111;
        rdata_c = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with valid/ready requests, wait states and sub-word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q, resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q, hold_word;
  acc_t              acc_q, live_acc, cur_acc;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic [31:0]       cur_word;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, rdata_c;
  logic [31:0]       mem [DEPTH_WORDS];

  assign addr   = bus.req_addr;
  assign idx    = addr[IDX_W+1:2];
  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    live_acc.write  = bus.req_write;
    live_acc.size   = bus.req_size;
    live_acc.sgn    = bus.req_signed;
    live_acc.offset = addr[1:0];
    live_acc.err    = size_misaligned(bus.req_size, addr[1:0]) ||
                      ((addr >> (IDX_W + 2)) != '0);
  end

  // In IDLE the live request is steered so a zero-latency load can respond at the acceptance edge.
  assign cur_acc  = (state == IDLE) ? live_acc : acc_q;
  assign cur_word = (state == IDLE) ? mem[idx] : hold_word;

  dmem_lane_align u_align (
    .size    (cur_acc.size),
    .offset  (cur_acc.offset),
    .sgn     (cur_acc.sgn),
    .wdata   (bus.req_wdata),
    .rword   (cur_word),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (LATENCY > 0) ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      acc_q        <= '0;
      hold_word    <= '0;
    end else begin
      state        <= state_nxt;
      ready_q      <= (state_nxt == IDLE);
      resp_valid_q <= (state_nxt == RESP);
      if (accept) begin
        acc_q     <= live_acc;
        hold_word <= mem[idx];
      end
      if (accept && (state_nxt == WAIT)) cnt <= CNT_INIT;
      else if ((state == WAIT) && (cnt != '0)) cnt <= cnt - CNT_W'(1);
      if (state_nxt == RESP) begin
        resp_err_q   <= cur_acc.err;
        resp_rdata_q <= (cur_acc.err || cur_acc.write) ? 32'd0 : rdata_c;
      end else begin
        resp_err_q   <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

  // Storage is never reset; stores commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && live_acc.write && !live_acc.err) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be_c[l]) mem[idx][8*l +: 8] <= wdata_c[8*l +: 8];
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: zero-latency and three-wait-state instances driven in lockstep.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned DEPTH     = 256;
  localparam int unsigned MEM_BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wr, sg, v0, v3;
  logic [1:0]  sz;
  logic [31:0] ad, wd;

  dmem_if #(.ADDR_W(32)) bus0 ();
  dmem_if #(.ADDR_W(32)) bus3 ();

  assign bus0.req_valid = v0;   assign bus3.req_valid = v3;
  assign bus0.req_write = wr;   assign bus3.req_write = wr;
  assign bus0.req_size  = sz;   assign bus3.req_size  = sz;
  assign bus0.req_signed = sg;  assign bus3.req_signed = sg;
  assign bus0.req_addr  = ad;   assign bus3.req_addr  = ad;
  assign bus0.req_wdata = wd;   assign bus3.req_wdata = wd;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference memory as a flat byte array addressed directly by byte address.
  logic [7:0] ref_mem [MEM_BYTES];

  task automatic model(input logic w, input logic [1:0] s, input logic g, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] r);
    int unsigned n;
    logic [31:0] v;
    n = 32'd1 << s;
    e = (s == 2'd3) || ((a % n) != 0) || (a >= MEM_BYTES);
    r = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < int'(n); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8*i));
        if (g && (n < 4) && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        r = v;
      end
    end
  endtask

  // One transaction on both instances; hold3 keeps the latency-3 request asserted into its wait.
  task automatic xact(input string nm, input logic w, input logic [1:0] s, input logic g,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic ee, input logic [31:0] er, input int hold3);
    logic [11:0] pv0, pv3, pr3;
    logic [31:0] rd0, rd3;
    logic        e0, e3;
    pv0 = '0; pv3 = '0; pr3 = '0;
    rd0 = 32'hFFFF_FFFF; rd3 = 32'hFFFF_FFFF; e0 = ~ee; e3 = ~ee;
    wr = w; sz = s; sg = g; ad = a; wd = d; v0 = 1'b1; v3 = 1'b1;
    chk({nm, " ready"}, 32'({bus0.req_ready, bus3.req_ready}), 32'd3);
    @(posedge clk);
    #1 v0 = 1'b0;
    if (hold3 == 0) v3 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      pv0[k] = bus0.resp_valid;
      pv3[k] = bus3.resp_valid;
      pr3[k] = bus3.req_ready;
      if (bus0.resp_valid) begin rd0 = bus0.resp_rdata; e0 = bus0.resp_err; end
      if (bus3.resp_valid) begin rd3 = bus3.resp_rdata; e3 = bus3.resp_err; end
      if (k == hold3) v3 = 1'b0;
    end
    chk({nm, " valid_l0"}, 32'(pv0), 32'h002);
    chk({nm, " valid_l3"}, 32'(pv3), 32'h010);
    chk({nm, " ready_l3"}, 32'(pr3), 32'hFE0);
    chk({nm, " rdata_l0"}, rd0, er);
    chk({nm, " err_l0"},   32'(e0), 32'(ee));
    chk({nm, " rdata_l3"}, rd3, er);
    chk({nm, " err_l3"},   32'(e3), 32'(ee));
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  s;
    logic        g;
    logic [31:0] a;
    logic [31:0] d;
    logic        ee;
    logic [31:0] er;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic w, input logic [1:0] s, input logic g,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic ee, input logic [31:0] er);
    vec_t t;
    t.name = nm; t.w = w; t.s = s; t.g = g; t.a = a; t.d = d; t.ee = ee; t.er = er;
    return t;
  endfunction

  function automatic logic [31:0] init_word(input int unsigned i);
    return {8'(i), 8'hC3, 8'h5A, ~8'(i)};
  endfunction

  task automatic count_pulses(input string nm, input int cycles);
    int p;
    p = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus3.resp_valid) p++;
    end
    chk(nm, 32'(p), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tab[$];
    logic        e, w, g;
    logic [1:0]  s;
    logic [31:0] r, a, d;
    int unsigned t;

    rst_n = 1'b0; v0 = 1'b0; v3 = 1'b0;
    wr = 1'b0; sz = 2'd0; sg = 1'b0; ad = 32'd0; wd = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst valid", 32'({bus0.resp_valid, bus3.resp_valid}), 32'd0);
    chk("rst err",   32'({bus0.resp_err, bus3.resp_err}), 32'd0);
    chk("rst rdata", bus0.resp_rdata | bus3.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", 32'({bus0.req_ready, bus3.req_ready}), 32'd3);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      model(1'b1, SZ_WORD, 1'b0, i * 4, init_word(i), e, r);
      xact("init", 1'b1, SZ_WORD, 1'b0, i * 4, init_word(i), e, r, 0);
    end

    tab.push_back(mk("st_word_10",   1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0));
    tab.push_back(mk("ld_word_10",   0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF));
    tab.push_back(mk("st_byte_21",   1, SZ_BYTE, 0, 32'h21, 32'h12345680, 0, 32'h0));
    tab.push_back(mk("ld_sbyte_21",  0, SZ_BYTE, 1, 32'h21, 32'h0, 0, 32'hFFFFFF80));
    tab.push_back(mk("ld_ubyte_21",  0, SZ_BYTE, 0, 32'h21, 32'h0, 0, 32'h00000080));
    tab.push_back(mk("ld_word_20",   0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h08C380F7));
    tab.push_back(mk("st_half_32",   1, SZ_HALF, 0, 32'h32, 32'hABCD8001, 0, 32'h0));
    tab.push_back(mk("ld_shalf_32",  0, SZ_HALF, 1, 32'h32, 32'h0, 0, 32'hFFFF8001));
    tab.push_back(mk("ld_uhalf_32",  0, SZ_HALF, 0, 32'h32, 32'h0, 0, 32'h00008001));
    tab.push_back(mk("ld_word_30",   0, SZ_WORD, 0, 32'h30, 32'h0, 0, 32'h80015AF3));
    tab.push_back(mk("ld_sbyte_33",  0, SZ_BYTE, 1, 32'h33, 32'h0, 0, 32'hFFFFFF80));
    tab.push_back(mk("ld_sbyte_32",  0, SZ_BYTE, 1, 32'h32, 32'h0, 0, 32'h00000001));
    tab.push_back(mk("err_ld_w13",   0, SZ_WORD, 0, 32'h13, 32'h0, 1, 32'h0));
    tab.push_back(mk("err_st_h41",   1, SZ_HALF, 0, 32'h41, 32'hFFFFFFFF, 1, 32'h0));
    tab.push_back(mk("err_ld_h41",   0, SZ_HALF, 1, 32'h41, 32'h0, 1, 32'h0));
    tab.push_back(mk("err_size3",    1, 2'b11,   0, 32'h40, 32'hFFFFFFFF, 1, 32'h0));
    tab.push_back(mk("err_st_oob",   1, SZ_WORD, 0, MEM_BYTES, 32'hFFFFFFFF, 1, 32'h0));
    tab.push_back(mk("err_ld_oob",   0, SZ_WORD, 0, MEM_BYTES, 32'h0, 1, 32'h0));
    tab.push_back(mk("err_st_hibit", 1, SZ_BYTE, 0, 32'h80000040, 32'hFF, 1, 32'h0));
    tab.push_back(mk("ld_word_40",   0, SZ_WORD, 0, 32'h40, 32'h0, 0, 32'h10C35AEF));
    tab.push_back(mk("ld_word_10b",  0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF));
    foreach (tab[i]) begin
      model(tab[i].w, tab[i].s, tab[i].g, tab[i].a, tab[i].d, e, r);
      xact(tab[i].name, tab[i].w, tab[i].s, tab[i].g, tab[i].a, tab[i].d, tab[i].ee, tab[i].er, 0);
    end

    // Request held through the wait states must be taken once.
    model(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, e, r);
    xact("hold_l3", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, e, r, 4);

    // Reset during the wait of a store: the store has already committed.
    model(1'b1, SZ_WORD, 1'b0, 32'h48, 32'hCAFE1234, e, r);
    wr = 1'b1; sz = SZ_WORD; sg = 1'b0; ad = 32'h48; wd = 32'hCAFE1234; v0 = 1'b1; v3 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0; v3 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid valid", 32'(bus3.resp_valid), 32'd0);
    chk("rst_mid ready", 32'(bus3.req_ready), 32'd1);
    rst_n = 1'b1;
    count_pulses("rst_st pulses", 8);

    // Reset during the wait of a load: no response may follow.
    wr = 1'b0; ad = 32'h10; v3 = 1'b1;
    @(posedge clk);
    #1 v3 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses("rst_ld pulses", 8);
    chk("rst_ld ready", 32'({bus0.req_ready, bus3.req_ready}), 32'd3);
    model(1'b0, SZ_WORD, 1'b0, 32'h48, 32'h0, e, r);
    xact("rst_keep_48", 1'b0, SZ_WORD, 1'b0, 32'h48, 32'h0, e, r, 0);

    for (int n = 0; n < 200; n++) begin
      t = $urandom_range(0, 15);
      s = (t == 0) ? 2'b11 : 2'(t % 3);
      w = 1'($urandom);
      g = 1'($urandom);
      d = $urandom;
      a = 32'($urandom_range(0, MEM_BYTES - 1));
      if ((s != 2'b11) && ($urandom_range(0, 3) != 0)) a = a & ~((32'd1 << s) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
      model(w, s, g, a, d, e, r);
      xact("rnd", w, s, g, a, d, e, r, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
